multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath. Replaces single-cycle opcode decode with a Moore FSM
//  that spreads each instruction over FETCH/DECODE/EXEC/MEM/WB steps. A shared memory port and the ALU
//  are reused across these steps. Sits between IR.opcode and the datapath muxes/enables; stalls on mem_ready.
// PARAMETERS
//  OPW   6   opcode width; bits [3:0] decoded, bits [OPW-1:4] must be 0 else illegal
//  CNTW  32  width of retired-instruction counter
// PORTS
//  clk           in   1     single clock, rising edge
//  rst           in   1     synchronous, active-high reset
//  opcode        in   OPW   IR opcode field, valid from DECODE onward
//  mem_ready     in   1     memory completes current read/write this cycle
//  halt          in   1     sampled in FETCH only; 1 = hold in FETCH, no access issued
//  pc_write      out  1     unconditional PC load
//  pc_write_cond out  1     PC load if datapath zero==0 (BNE)
//  pc_src        out  2     00 ALU result (PC+4), 01 ALUOut (branch target)
//  ir_write      out  1     load IR from memory data
//  iord          out  1     0 = PC addresses memory, 1 = ALUOut
//  mem_read      out  1     memory read request
//  mem_write     out  1     memory write request
//  reg_write     out  1     register-file write enable
//  reg_dst       out  1     1 = rd, 0 = rt
//  mem_to_reg    out  1     1 = MDR, 0 = ALUOut
//  alu_src_a     out  1     0 = PC, 1 = regA
//  alu_src_b     out  2     00 regB, 01 const 4, 10 sext imm, 11 sext imm<<2
//  alu_op        out  3     000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT
//  illegal_op    out  1     1-cycle pulse in DECODE on an unsupported opcode
//  state         out  4     current FSM state (debug)
//  instr_count   out  CNTW  retired instructions; wraps modulo 2^CNTW
// BEHAVIOUR
//  - Reset: state=FETCH, instr_count=0, op_q=0. All enables are 0 during rst=1.
//    During rst=1, alu_src_b=00, alu_op=000, pc_src=00 and iord=0. rst mid-instruction aborts it;
//    next cycle is FETCH with no write.
//  - Opcodes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, LW 1000, SW 1010, BNE 1110.
//    op_q latched in DECODE; EXEC..WB use op_q only.
//  - Outputs are Moore (state + op_q). Exception: pc_write and ir_write in FETCH, qualified by mem_ready.
//    Unlisted outputs are 0 in each state.
//  - FETCH: if halt, stay with all enables 0.
//    Else mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
//    Wait while !mem_ready; on mem_ready: ir_write=1, pc_write=1, pc_src=00, go DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precompute branch target).
//    Next state: R-type (AND/OR/ADD/SUB/SLT) -> EXEC_R; LW/SW -> ADDR; BNE -> BRANCH;
//    else illegal_op=1 -> FETCH.
//  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op per opcode -> WB_R.
//  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD -> MEM_RD (LW) / MEM_WR (SW).
//  - MEM_RD: mem_read=1, iord=1; hold until mem_ready -> WB_MEM.
//  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  - MEM_WR: mem_write=1, iord=1; hold until mem_ready -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_src=01 -> FETCH.
//  - Latency with mem_ready=1: R-type 4, LW 5, SW 4, BNE 3 cycles; each memory wait cycle adds 1.
//  - instr_count increments exactly once on leaving WB_R, WB_MEM, MEM_WR (on mem_ready) or BRANCH.
//    Illegal opcodes and halt cycles do not count. Counter wraps from all-ones to 0.
//  - mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.
//  - Unused state encodings go to FETCH with all enables 0.
// STRUCTURE
//  - mips_pkg: opcode localparams, ALU_op codes, alu_src_b/pc_src encodings, state encoding.
//  - Sub-module ctrl_opclass: combinational opcode -> {is_rtype, is_lw, is_sw, is_bne, illegal, alu_fn}.
//  - Top: state register, op_q register, counter, and the output decode case.
// TESTING
//  1. rst=1 two cycles, mem_ready=1 -> state=FETCH, all enables 0, instr_count=0.
//  2. ADD (000010), mem_ready=1 -> FETCH,DECODE,EXEC_R(alu_op=010),WB_R(reg_write=1,reg_dst=1);
//     instr_count 0->1.
//  3. LW (001000), mem_ready low 3 cycles in MEM_RD -> mem_read=1, iord=1 held;
//     WB_MEM mem_to_reg=1 at cycle 8.
//  4. SW (001010) then BNE (001110) -> mem_write=1 in MEM_WR, no reg_write.
//     BRANCH: alu_op=011, pc_write_cond=1, pc_src=01; count +2.
//  5. Illegal 000011 and 110010 -> illegal_op pulse in DECODE, back to FETCH, count unchanged.
//  6. rst during MEM_WR with mem_ready=0 -> next cycle FETCH, mem_write=0; halt=1 holds FETCH, mem_read=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALU functions,
// datapath mux selects and the sequencer state encoding.
package mips_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_BNE = 4'b1110;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_WB_MEM = 4'd6,
        S_MEM_WR = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

endpackage

// File: rtl/ctrl_opclass.sv
// Combinational opcode classifier: instruction class, legality and the ALU
// function an R-type instruction needs in its execute step.
module ctrl_opclass
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output logic           is_rtype,
    output logic           is_lw,
    output logic           is_sw,
    output logic           is_bne,
    output logic           illegal,
    output logic [2:0]     alu_fn
);

    logic hi_zero;

    // Any set bit above the decoded nibble makes the opcode illegal.
    assign hi_zero = (opcode >> 4) == '0;

    always_comb begin
        is_rtype = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_bne   = 1'b0;
        illegal  = 1'b0;
        alu_fn   = ALU_ADD;
        case (opcode[3:0])
            OP_AND: begin is_rtype = 1'b1; alu_fn = ALU_AND; end
            OP_OR:  begin is_rtype = 1'b1; alu_fn = ALU_OR;  end
            OP_ADD: begin is_rtype = 1'b1; alu_fn = ALU_ADD; end
            OP_SUB: begin is_rtype = 1'b1; alu_fn = ALU_SUB; end
            OP_SLT: begin is_rtype = 1'b1; alu_fn = ALU_SLT; end
            OP_LW:  is_lw  = 1'b1;
            OP_SW:  is_sw  = 1'b1;
            OP_BNE: is_bne = 1'b1;
            default: illegal = 1'b1;
        endcase
        if (!hi_zero) begin
            is_rtype = 1'b0;
            is_lw    = 1'b0;
            is_sw    = 1'b0;
            is_bne   = 1'b0;
            illegal  = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: Moore FSM driving datapath muxes/enables across
// FETCH/DECODE/EXEC/MEM/WB steps, with a retired-instruction counter.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_ready,
    input  logic            halt,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic [1:0]      pc_src,
    output logic            ir_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      alu_op,
    output logic            illegal_op,
    output logic [3:0]      state,
    output logic [CNTW-1:0] instr_count
);

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] cls_op;
    logic           retire;
    logic           cls_rtype;
    logic           cls_lw;
    logic           cls_sw;
    logic           cls_bne;
    logic           cls_illegal;
    logic [2:0]     cls_alu_fn;

    // The live opcode is only trusted in DECODE; later steps use the latched copy.
    assign cls_op = (state_q == S_DECODE) ? opcode : op_q;
    assign state  = state_q;

    ctrl_opclass #(.OPW(OPW)) u_opclass (
        .opcode   (cls_op),
        .is_rtype (cls_rtype),
        .is_lw    (cls_lw),
        .is_sw    (cls_sw),
        .is_bne   (cls_bne),
        .illegal  (cls_illegal),
        .alu_fn   (cls_alu_fn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (retire) begin
                instr_count <= instr_count + CNTW'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALU_AND;
        illegal_op    = 1'b0;
        // Reset forces every output quiet regardless of the state being aborted.
        if (rst) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!halt) begin
                        mem_read  = 1'b1;
                        alu_src_b = SRCB_FOUR;
                        alu_op    = ALU_ADD;
                        if (mem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                            state_d  = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    alu_op    = ALU_ADD;
                    if (cls_illegal) begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end else if (cls_rtype) begin
                        state_d = S_EXEC_R;
                    end else if (cls_lw || cls_sw) begin
                        state_d = S_ADDR;
                    end else if (cls_bne) begin
                        state_d = S_BRANCH;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_REGB;
                    alu_op    = cls_alu_fn;
                    state_d   = S_WB_R;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                    state_d   = cls_lw ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        state_d = S_WB_MEM;
                    end
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = SRCB_REGB;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = PCSRC_ALUOUT;
                    retire        = 1'b1;
                    state_d       = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl: table of per-cycle expectations plus
// hand-written latency sequences.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        halt;
    logic        pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        halt;
        logic        ready;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    logic [17:0] w_zero, w_fwait, w_fgo, w_dec, w_ill, w_wbr, w_addr;
    logic [17:0] w_memrd, w_wbmem, w_memwr, w_br;
    logic [17:0] w_and, w_or, w_add, w_sub, w_slt;

    multicycle_ctrl #(.OPW(6), .CNTW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .halt          (halt),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .ir_write      (ir_write),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .state         (state),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    // Control word field order: pcw pcwc pcsrc irw iord mr mw rw rd m2r asa asb aop ill
    function automatic logic [17:0] mk(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                       input logic irw, input logic io, input logic mr,
                                       input logic mw, input logic rw, input logic rd,
                                       input logic m2r, input logic asa, input logic [1:0] asb,
                                       input logic [2:0] aop, input logic ill);
        return {pcw, pcwc, pcs, irw, io, mr, mw, rw, rd, m2r, asa, asb, aop, ill};
    endfunction

    function automatic logic [17:0] act_ctl();
        return {pc_write, pc_write_cond, pc_src, ir_write, iord, mem_read, mem_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op};
    endfunction

    task automatic addVec(input logic r, input logic h, input logic rdy, input logic [5:0] op,
                          input logic [3:0] st, input logic [17:0] ctl, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.halt = h; v.ready = rdy; v.op = op; v.st = st; v.ctl = ctl; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check({tag, ".state"}, 32'(state), 32'(v.st));
        check({tag, ".ctl"}, 32'(act_ctl()), 32'(v.ctl));
        check({tag, ".count"}, instr_count, v.cnt);
        check({tag, ".excl"}, {30'd0, mem_read & mem_write, reg_write & mem_write}, 32'd0);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        rst       = v.rst;
        halt      = v.halt;
        mem_ready = v.ready;
        opcode    = v.op;
        @(negedge clk);
        checkOutput(idx, v);
        @(posedge clk);
        #1;
    endtask

    task automatic measureLatency(input string name, input logic [5:0] op, input int exp);
        int cycles;
        rst = 1'b0; halt = 1'b0; mem_ready = 1'b1; opcode = op;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (state != 4'd0 && cycles < 20);
        check({name, ".latency"}, 32'(cycles), 32'(exp));
    endtask

    initial begin
        w_zero  = '0;
        w_fwait = mk(0,0,2'b00,0,0,1,0,0,0,0,0,2'b01,3'b010,0);
        w_fgo   = mk(1,0,2'b00,1,0,1,0,0,0,0,0,2'b01,3'b010,0);
        w_dec   = mk(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,3'b010,0);
        w_ill   = mk(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,3'b010,1);
        w_wbr   = mk(0,0,2'b00,0,0,0,0,1,1,0,0,2'b00,3'b000,0);
        w_addr  = mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,3'b010,0);
        w_memrd = mk(0,0,2'b00,0,1,1,0,0,0,0,0,2'b00,3'b000,0);
        w_wbmem = mk(0,0,2'b00,0,0,0,0,1,0,1,0,2'b00,3'b000,0);
        w_memwr = mk(0,0,2'b00,0,1,0,1,0,0,0,0,2'b00,3'b000,0);
        w_br    = mk(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,3'b011,0);
        w_and   = mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,3'b000,0);
        w_or    = mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,3'b001,0);
        w_add   = mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,3'b010,0);
        w_sub   = mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,3'b011,0);
        w_slt   = mk(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,3'b100,0);

        //     rst h rdy op          st  ctl      cnt
        addVec(1, 0, 1, 6'b000000, 0, w_zero,  0);   // reset held
        addVec(0, 0, 1, 6'b000010, 0, w_fgo,   0);   // ADD
        addVec(0, 0, 1, 6'b000010, 1, w_dec,   0);
        addVec(0, 0, 1, 6'b111111, 2, w_add,   0);   // op_q must be used
        addVec(0, 0, 1, 6'b111111, 3, w_wbr,   0);
        addVec(0, 0, 0, 6'b000000, 0, w_fwait, 1);
        addVec(0, 0, 1, 6'b001000, 0, w_fgo,   1);   // LW, 3 wait cycles
        addVec(0, 0, 1, 6'b001000, 1, w_dec,   1);
        addVec(0, 0, 1, 6'b000010, 4, w_addr,  1);
        addVec(0, 0, 0, 6'b000010, 5, w_memrd, 1);
        addVec(0, 0, 0, 6'b000010, 5, w_memrd, 1);
        addVec(0, 0, 0, 6'b000010, 5, w_memrd, 1);
        addVec(0, 0, 1, 6'b000010, 5, w_memrd, 1);
        addVec(0, 0, 1, 6'b000010, 6, w_wbmem, 1);
        addVec(0, 0, 1, 6'b001010, 0, w_fgo,   2);   // SW
        addVec(0, 0, 1, 6'b001010, 1, w_dec,   2);
        addVec(0, 0, 1, 6'b001010, 4, w_addr,  2);
        addVec(0, 0, 1, 6'b001010, 7, w_memwr, 2);
        addVec(0, 0, 1, 6'b001110, 0, w_fgo,   3);   // BNE
        addVec(0, 0, 1, 6'b001110, 1, w_dec,   3);
        addVec(0, 0, 1, 6'b001110, 8, w_br,    3);
        addVec(0, 0, 1, 6'b000011, 0, w_fgo,   4);   // illegal low nibble
        addVec(0, 0, 1, 6'b000011, 1, w_ill,   4);
        addVec(0, 0, 1, 6'b110010, 0, w_fgo,   4);   // illegal high bits
        addVec(0, 0, 1, 6'b110010, 1, w_ill,   4);
        addVec(0, 0, 0, 6'b000000, 0, w_fwait, 4);
        addVec(0, 0, 1, 6'b000110, 0, w_fgo,   4);   // SUB
        addVec(0, 0, 1, 6'b000110, 1, w_dec,   4);
        addVec(0, 0, 1, 6'b000110, 2, w_sub,   4);
        addVec(0, 0, 1, 6'b000110, 3, w_wbr,   4);
        addVec(0, 0, 1, 6'b000111, 0, w_fgo,   5);   // SLT
        addVec(0, 0, 1, 6'b000111, 1, w_dec,   5);
        addVec(0, 0, 1, 6'b000111, 2, w_slt,   5);
        addVec(0, 0, 1, 6'b000111, 3, w_wbr,   5);
        addVec(0, 0, 1, 6'b000001, 0, w_fgo,   6);   // OR
        addVec(0, 0, 1, 6'b000001, 1, w_dec,   6);
        addVec(0, 0, 1, 6'b000001, 2, w_or,    6);
        addVec(0, 0, 1, 6'b000001, 3, w_wbr,   6);
        addVec(0, 1, 1, 6'b000000, 0, w_zero,  7);   // halt holds FETCH
        addVec(0, 1, 0, 6'b000000, 0, w_zero,  7);
        addVec(0, 0, 1, 6'b001010, 0, w_fgo,   7);   // SW aborted by reset
        addVec(0, 0, 1, 6'b001010, 1, w_dec,   7);
        addVec(0, 0, 1, 6'b001010, 4, w_addr,  7);
        addVec(0, 0, 0, 6'b001010, 7, w_memwr, 7);
        addVec(1, 0, 0, 6'b001010, 7, w_zero,  7);
        addVec(0, 0, 0, 6'b001010, 0, w_fwait, 0);
        addVec(0, 1, 0, 6'b000000, 0, w_zero,  0);
        addVec(0, 0, 1, 6'b000000, 0, w_fgo,   0);   // AND
        addVec(0, 0, 1, 6'b000000, 1, w_dec,   0);
        addVec(0, 0, 1, 6'b000000, 2, w_and,   0);
        addVec(0, 0, 1, 6'b000000, 3, w_wbr,   0);
        addVec(0, 0, 0, 6'b000000, 0, w_fwait, 1);

        rst = 1'b1; halt = 1'b0; mem_ready = 1'b1; opcode = '0;
        @(posedge clk);
        #1;
        foreach (vecs[i]) applyStimulus(i, vecs[i]);

        measureLatency("bne", 6'b001110, 3);
        measureLatency("add", 6'b000010, 4);
        measureLatency("lw",  6'b001000, 5);
        measureLatency("sw",  6'b001010, 4);
        @(negedge clk);
        check("latency.count", instr_count, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
